// File: rtl/conv_encoder_framer.sv
// K=3 rate-1/2 convolutional encoder (g0=111, g1=101) with framing.
// Serial bits in, one {g0,g1} symbol per divider slot, 2 zero tail bits per frame.
module conv_encoder_framer #(
    parameter int SYM_DIV   = 50,
    parameter int FRAME_LEN = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic [1:0] sym,
    output logic       sym_strobe,
    output logic       frame_active,
    output logic       frame_done,
    output logic       underrun
);

    localparam int DW = (SYM_DIV > 1) ? $clog2(SYM_DIV) : 1;
    localparam int BW = $clog2(FRAME_LEN + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SYM_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_LEN);
    localparam bit ONE_BIT_FRAME = (FRAME_LEN == 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_TAIL
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic          tail_cnt_q, tail_cnt_d;
    logic          d1_q, d1_d;
    logic          d2_q, d2_d;
    logic [1:0]    sym_q, sym_d;
    logic          strobe_q, strobe_d;
    logic          active_q, active_d;
    logic          done_q, done_d;
    logic          under_q, under_d;

    logic tick;
    logic accept;
    logic enc_en;
    logic enc_b;

    assign tick      = (div_cnt_q == DIV_LAST);
    assign din_ready = tick & ((state_q == S_IDLE) | (state_q == S_DATA));
    assign accept    = din_valid & din_ready;

    // Free-running symbol slot divider
    always_comb begin
        div_cnt_d = tick ? '0 : div_cnt_q + DW'(1);
    end

    // Frame sequencing, encoder update and registered output pulses
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        tail_cnt_d = tail_cnt_q;
        d1_d       = d1_q;
        d2_d       = d2_q;
        sym_d      = sym_q;
        strobe_d   = 1'b0;
        done_d     = 1'b0;
        under_d    = 1'b0;
        enc_en     = 1'b0;
        enc_b      = din;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    enc_en     = 1'b1;
                    bit_cnt_d  = BW'(1);
                    tail_cnt_d = 1'b0;
                    state_d    = ONE_BIT_FRAME ? S_TAIL : S_DATA;
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (din_valid) begin
                        enc_en    = 1'b1;
                        bit_cnt_d = bit_cnt_q + BW'(1);
                        if ((bit_cnt_q + BW'(1)) == BIT_LAST) begin
                            state_d    = S_TAIL;
                            tail_cnt_d = 1'b0;
                        end
                    end else begin
                        under_d = 1'b1;
                    end
                end
            end
            S_TAIL: begin
                if (tick) begin
                    enc_en     = 1'b1;
                    enc_b      = 1'b0;
                    tail_cnt_d = 1'b1;
                    if (tail_cnt_q) begin
                        done_d    = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (enc_en) begin
            sym_d    = {enc_b ^ d1_q ^ d2_q, enc_b ^ d2_q};
            d2_d     = d1_q;
            d1_d     = enc_b;
            strobe_d = 1'b1;
        end

        active_d = (state_d != S_IDLE) | done_d;
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            div_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            tail_cnt_q <= 1'b0;
            d1_q       <= 1'b0;
            d2_q       <= 1'b0;
            sym_q      <= 2'b00;
            strobe_q   <= 1'b0;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
            under_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            tail_cnt_q <= tail_cnt_d;
            d1_q       <= d1_d;
            d2_q       <= d2_d;
            sym_q      <= sym_d;
            strobe_q   <= strobe_d;
            active_q   <= active_d;
            done_q     <= done_d;
            under_q    <= under_d;
        end
    end

    assign sym          = sym_q;
    assign sym_strobe   = strobe_q;
    assign frame_active = active_q;
    assign frame_done   = done_q;
    assign underrun     = under_q;

endmodule

// File: tb/tb_conv_encoder_framer.sv
// Testbench for conv_encoder_framer: directed frames plus random traffic
// against a convolution-sum reference of the K=3 (7,5) code.
module tb_conv_encoder_framer;

    localparam int SYM_DIV   = 10;
    localparam int FRAME_LEN = 4;
    localparam int CLK_P     = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       din = 1'b0;
    logic       din_valid = 1'b0;
    logic       din_ready;
    logic [1:0] sym;
    logic       sym_strobe;
    logic       frame_active;
    logic       frame_done;
    logic       underrun;

    conv_encoder_framer #(
        .SYM_DIV  (SYM_DIV),
        .FRAME_LEN(FRAME_LEN)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .din         (din),
        .din_valid   (din_valid),
        .din_ready   (din_ready),
        .sym         (sym),
        .sym_strobe  (sym_strobe),
        .frame_active(frame_active),
        .frame_done  (frame_done),
        .underrun    (underrun)
    );

    always #(CLK_P / 2) clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: bits of current frame and frame progress
    bit         fbits[FRAME_LEN];
    int         m_nbits;
    int         m_tail;
    bit         m_inframe;
    logic [1:0] exp_sym;

    logic [1:0] got[$];
    time        done_t[$];
    int         n_under;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit xb(input int j);
        if (j >= 0 && j < FRAME_LEN) return fbits[j];
        return 1'b0;
    endfunction

    // symbol i of a frame as a convolution sum with zero padding
    function automatic logic [1:0] ref_sym(input int i);
        return {xb(i) ^ xb(i - 1) ^ xb(i - 2), xb(i) ^ xb(i - 2)};
    endfunction

    task automatic model_reset();
        m_nbits   = 0;
        m_tail    = 0;
        m_inframe = 1'b0;
        exp_sym   = 2'b00;
    endtask

    // one symbol slot; entered and left at the negedge where div_cnt==0
    task automatic slot(input bit v, input bit b);
        bit exp_stb, exp_done, exp_und, exp_rdy;
        din       = 1'($urandom);
        din_valid = 1'($urandom);
        for (int i = 1; i < SYM_DIV; i++) begin
            @(negedge clk);
            if (i == 1) begin
                chk("mid_strobe", sym_strobe, 0);
                chk("mid_done", frame_done, 0);
                chk("mid_under", underrun, 0);
                chk("mid_ready", din_ready, 0);
                chk("mid_active", frame_active, m_inframe);
            end
            if (i == SYM_DIV - 2) begin
                din       = b;
                din_valid = v;
            end
        end
        exp_rdy = !(m_inframe && m_nbits == FRAME_LEN);
        chk("tick_ready", din_ready, exp_rdy);
        chk("tick_strobe", sym_strobe, 0);
        exp_stb  = 1'b0;
        exp_done = 1'b0;
        exp_und  = 1'b0;
        if (m_inframe && m_nbits == FRAME_LEN) begin
            exp_sym = ref_sym(FRAME_LEN + m_tail);
            exp_stb = 1'b1;
            m_tail++;
            if (m_tail == 2) begin
                exp_done  = 1'b1;
                m_inframe = 1'b0;
                m_nbits   = 0;
                m_tail    = 0;
            end
        end else if (v) begin
            fbits[m_nbits] = b;
            exp_sym        = ref_sym(m_nbits);
            m_nbits++;
            exp_stb   = 1'b1;
            m_inframe = 1'b1;
        end else if (m_inframe) begin
            exp_und = 1'b1;
        end
        @(negedge clk);
        chk("strobe", sym_strobe, exp_stb);
        chk("sym", sym, exp_sym);
        chk("done", frame_done, exp_done);
        chk("underrun", underrun, exp_und);
        chk("active", frame_active, m_inframe || exp_done);
        if (sym_strobe) got.push_back(sym);
        if (frame_done) done_t.push_back($time);
        if (underrun) n_under++;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        din_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        got.delete();
        done_t.delete();
        n_under = 0;
    endtask

    function automatic logic [31:0] pack_got();
        logic [31:0] p = '0;
        foreach (got[k]) p = {p[29:0], got[k]};
        return p;
    endfunction

    initial begin
        // reset state
        #1;
        chk("rst_sym", sym, 0);
        chk("rst_strobe", sym_strobe, 0);
        chk("rst_active", frame_active, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_under", underrun, 0);
        do_reset();

        // idle: no valid for three slots
        repeat (3) slot(1'b0, 1'b0);
        chk("idle_nostrobe", got.size(), 0);

        // frame 1,0,1,1
        slot(1, 1); slot(1, 0); slot(1, 1); slot(1, 1);
        slot(0, 0); slot(0, 0);
        chk("f1011_count", got.size(), 6);
        chk("f1011_seq", pack_got(), 32'b11_10_00_01_01_11);
        chk("f1011_done", done_t.size(), 1);
        slot(0, 0);

        // one-slot underrun after the second bit
        got.delete();
        done_t.delete();
        n_under = 0;
        slot(1, 1); slot(1, 0); slot(0, 1); slot(1, 1); slot(1, 1);
        slot(0, 0); slot(0, 0);
        chk("und_count", n_under, 1);
        chk("und_seq", pack_got(), 32'b11_10_00_01_01_11);
        chk("und_done", done_t.size(), 1);

        // reset during the third slot of a frame
        slot(1, 1); slot(1, 0);
        din       = 1'b1;
        din_valid = 1'b1;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mrst_sym", sym, 0);
        chk("mrst_active", frame_active, 0);
        chk("mrst_strobe", sym_strobe, 0);
        chk("mrst_done", frame_done, 0);
        chk("mrst_ready", din_ready, 0);
        do_reset();
        slot(1, 1); slot(1, 0); slot(1, 1); slot(1, 1);
        slot(0, 0); slot(0, 0);
        chk("mrst_seq", pack_got(), 32'b11_10_00_01_01_11);
        chk("mrst_done_cnt", done_t.size(), 1);

        // back-to-back frames, valid and din held high
        got.delete();
        done_t.delete();
        repeat (2 * (FRAME_LEN + 2)) slot(1, 1);
        chk("b2b_done_cnt", done_t.size(), 2);
        if (done_t.size() == 2)
            chk("b2b_spacing", 32'(done_t[1] - done_t[0]),
                32'((FRAME_LEN + 2) * SYM_DIV * CLK_P));
        chk("b2b_seq", pack_got(),
            32'({12'b11_01_10_10_01_11, 12'b11_01_10_10_01_11}));

        // random traffic with gaps
        for (int k = 0; k < 80; k++)
            slot(($urandom_range(3) != 0), 1'($urandom));

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
